// File: rtl/mem_arbiter.sv
// Two-port round-robin memory arbiter: IF and LS share one memory port, one transaction in flight.
// Requests are latched on grant, issued over valid/ready, and the response is routed back to the owner.
module mem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rsp_data,
    input  logic                ls_req_valid,
    output logic                ls_req_ready,
    input  logic [ADDR_W-1:0]   ls_req_addr,
    input  logic                ls_req_wen,
    input  logic [DATA_W-1:0]   ls_req_wdata,
    input  logic [DATA_W/8-1:0] ls_req_wmask,
    output logic                ls_rsp_valid,
    output logic [DATA_W-1:0]   ls_rsp_data,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_wen,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wmask,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_data,
    output logic                owner,
    output logic                proto_err
);

    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MASK_W-1:0]   wmask_q, wmask_d;
    logic                proto_err_q, proto_err_d;

    logic                win_ls;
    logic                accept;

    // On a tie the requester that was not granted last wins.
    always_comb begin
        win_ls = ls_req_valid;
        if (if_req_valid && ls_req_valid) begin
            win_ls = ~owner_q;
        end
        accept = (state_q == S_IDLE) && (if_req_valid || ls_req_valid);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            wen_q       <= wen_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            proto_err_q <= proto_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept)        state_d = S_ISSUE;
            S_ISSUE: if (mem_req_ready) state_d = S_WAIT;
            S_WAIT:  if (mem_rsp_valid) state_d = S_IDLE;
            default:                    state_d = S_IDLE;
        endcase
    end

    // Request fields are captured only at grant; IF is always a plain read.
    always_comb begin
        owner_d = owner_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        if (accept) begin
            owner_d = win_ls;
            if (win_ls) begin
                addr_d  = ls_req_addr;
                wen_d   = ls_req_wen;
                wdata_d = ls_req_wdata;
                wmask_d = ls_req_wmask;
            end else begin
                addr_d  = if_req_addr;
                wen_d   = 1'b0;
                wdata_d = '0;
                wmask_d = '0;
            end
        end
        proto_err_d = proto_err_q | (mem_rsp_valid && (state_q != S_WAIT));
    end

    // Readies are masked by reset so nothing looks grantable while reset is held.
    always_comb begin
        if_req_ready  = 1'b0;
        ls_req_ready  = 1'b0;
        mem_req_valid = 1'b0;
        if_rsp_valid  = 1'b0;
        ls_rsp_valid  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if_req_ready = !reset && if_req_valid && !win_ls;
                ls_req_ready = !reset && ls_req_valid && win_ls;
            end
            S_ISSUE: mem_req_valid = 1'b1;
            S_WAIT: begin
                if_rsp_valid = mem_rsp_valid && !owner_q;
                ls_rsp_valid = mem_rsp_valid && owner_q;
            end
            default: ;
        endcase
    end

    assign if_rsp_data   = mem_rsp_data;
    assign ls_rsp_data   = mem_rsp_data;
    assign mem_req_addr  = addr_q;
    assign mem_req_wen   = wen_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wmask = wmask_q;
    assign owner         = owner_q;
    assign proto_err     = proto_err_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter placed between the `core` instruction-fetch (IF) and load/store (LS) units and the single memory port of the simulation top. It accepts one request at a time from either requester using round-robin priority. It forwards the request to memory over a valid/ready handshake, waits for the memory response, and routes that response back to the owning requester. Only one transaction is outstanding at any time, which keeps memory ordering trivially in-order for both units.

## Interface
Parameters:
- `ADDR_W`, 64, address width in bits.
- `DATA_W`, 64, data width in bits; must be a multiple of 8.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `if_req_valid`  in  1  IF read request valid.
- `if_req_ready`  out  1  IF request accepted this cycle when `if_req_valid` is also high.
- `if_req_addr`  in  ADDR_W  IF read address.
- `if_rsp_valid`  out  1  IF response valid, one-cycle pulse.
- `if_rsp_data`  out  DATA_W  IF read data.
- `ls_req_valid`  in  1  LS request valid.
- `ls_req_ready`  out  1  LS request accepted this cycle when `ls_req_valid` is also high.
- `ls_req_addr`  in  ADDR_W  LS address.
- `ls_req_wen`  in  1  1 = write, 0 = read.
- `ls_req_wdata`  in  DATA_W  write data.
- `ls_req_wmask`  in  DATA_W/8  byte write enables.
- `ls_rsp_valid`  out  1  LS response valid, one-cycle pulse; reads and writes both get one.
- `ls_rsp_data`  out  DATA_W  LS read data; don't-care for writes.
- `mem_req_valid`  out  1  memory request valid.
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_req_addr`, `mem_req_wen`, `mem_req_wdata`, `mem_req_wmask`  out  ADDR_W/1/DATA_W/DATA_W/8  latched request fields.
- `mem_rsp_valid`  in  1  memory response valid.
- `mem_rsp_data`  in  DATA_W  memory read data.
- `owner`  out  1  0 = IF, 1 = LS; requester of the current or last grant.
- `proto_err`  out  1  sticky flag; set when `mem_rsp_valid` arrives outside WAIT.

## Operation
- FSM states: IDLE, ISSUE, WAIT. Reset state is IDLE.
- **IDLE**
  - The winner is chosen combinationally.
  - If only one requester is valid, that requester wins.
  - If both are valid, the winner is the requester that was not granted last (`owner` inverted).
  - `x_req_ready` = 1 only for the winner and only in IDLE.
  - On handshake: latch addr/wen/wdata/wmask, set `owner` to the winner, and go to ISSUE.
  - IF requests latch `wen` = 0, `wmask` = 0, `wdata` = 0.
- **ISSUE**
  - `mem_req_valid` = 1, driven from the latched registers.
  - Registers stay stable until `mem_req_ready`; then go to WAIT.
- **WAIT**
  - `mem_req_valid` = 0.
  - On `mem_rsp_valid`: assert the owner's `x_rsp_valid` in the same cycle (combinational pass-through), with `x_rsp_data` = `mem_rsp_data`. Go to IDLE.
  - The non-owner's `rsp_valid` stays 0.
- `mem_rsp_valid` in IDLE or ISSUE is ignored (not forwarded) and sets `proto_err`. Only `reset` clears `proto_err`.
- Both `rsp_data` outputs are driven from `mem_rsp_data` at all times; they are qualified only by their valids.
- Reset values:
  - all `*_ready`, `*_valid` outputs = 0
  - `mem_req_*` fields = 0
  - `owner` = 0, so LS wins the first tie
  - `proto_err` = 0
- Reset asserted mid-transaction: the FSM returns to IDLE immediately and the in-flight request is dropped; no response is delivered to either requester. A late memory response after reset release sets `proto_err`.

## Timing
- Request accepted in cycle T → `mem_req_valid` high from T+1.
- `mem_req_ready` in cycle M (M ≥ T+1) → WAIT from M+1.
- `mem_rsp_valid` in cycle R (R ≥ M+1) → `x_rsp_valid` in cycle R (0-cycle response latency).
- Earliest next acceptance is R+1. Minimum transaction period is 3 cycles with a zero-wait memory.
- No combinational path from `mem_req_ready` to any `x_req_ready`.
- Requester valids may drop without a handshake; no grant is held for them.

## Test plan
- Single IF read addr 0x1000, memory ready immediately, response data 0xDEAD_BEEF two cycles later:
  - `if_req_ready` at T
  - `mem_req_valid` at T+1
  - `if_rsp_valid` with 0xDEAD_BEEF at T+3
  - `ls_rsp_valid` never asserted
- Both valid continuously from reset: grants alternate LS, IF, LS, IF; `owner` toggles after each acceptance; 4 transactions complete in 12 cycles with zero-wait memory.
- LS write addr 0x20, wdata 0x1122334455667788, wmask 0x0F, memory holds `mem_req_ready` low 3 cycles:
  - `mem_req_*` stable throughout
  - `ls_rsp_valid` pulses exactly once
- Inject `mem_rsp_valid` while in IDLE: no `rsp_valid` on either side; `proto_err` = 1 and stays 1 until reset.
- Assert `reset` during WAIT:
  - all outputs go to 0 asynchronously
  - after release, the delayed `mem_rsp_valid` is not forwarded and sets `proto_err`
  - the next IF request completes normally
- IF valid drops before a grant because LS won: no IF transaction issued; LS completes with correct data.
